jtgng_dwnld_packer: RTL



---
 rtl/jtgng_dwnld_packer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/jtgng_dwnld_packer.sv
// Packs the loader's byte download stream into 16-bit SDRAM words, buffers them
// in a small FIFO and drains them over a req/ack handshake to the SDRAM write port.
module jtgng_dwnld_packer #(
    parameter int AW    = 22,
    parameter int DEPTH = 4,
    parameter int SWAP  = 0
) (
    input  logic          clk_rom,
    input  logic          rst_n,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    input  logic          downloading,
    output logic          sdram_req,
    output logic [AW-2:0] sdram_addr,
    output logic [15:0]   sdram_din,
    output logic [1:0]    sdram_dsn,
    input  logic          sdram_ack,
    output logic          dwnld_busy,
    output logic          overflow,
    output logic [AW-2:0] word_cnt
);

    localparam int WA = AW - 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic SWAP_L = (SWAP != 0);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Download edge detection
    logic dl_q;
    logic dl_rise;
    logic dl_fall;
    logic wr_acc;

    assign dl_rise = downloading & ~dl_q;
    assign dl_fall = ~downloading & dl_q;
    assign wr_acc  = ioctl_wr & downloading;

    // Byte lane of the incoming strobe: 1 selects din[15:8]
    logic          lane;
    logic [1:0]    lane_be;
    logic [15:0]   lane_data;
    logic [15:0]   merged_data;
    logic [WA-1:0] in_waddr;

    assign lane        = ioctl_addr[0] ^ SWAP_L;
    assign lane_be     = lane ? 2'b10 : 2'b01;
    assign lane_data   = lane ? {ioctl_data, 8'h00} : {8'h00, ioctl_data};
    assign in_waddr    = ioctl_addr[AW-1:1];

    // Pending word register
    logic          pvalid_q, pvalid_d;
    logic [WA-1:0] paddr_q, paddr_d;
    logic [15:0]   pdata_q, pdata_d;
    logic [1:0]    pbe_q, pbe_d;

    assign merged_data = lane ? {ioctl_data, pdata_q[7:0]} : {pdata_q[15:8], ioctl_data};

    // Word offered to the FIFO this cycle
    logic          push;
    logic [WA-1:0] push_addr;
    logic [15:0]   push_data;
    logic [1:0]    push_be;

    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    always_comb begin
        pvalid_d  = pvalid_q;
        paddr_d   = paddr_q;
        pdata_d   = pdata_q;
        pbe_d     = pbe_q;
        push      = 1'b0;
        push_addr = paddr_q;
        push_data = pdata_q;
        push_be   = pbe_q;

        if (wr_acc) begin
            if (!pvalid_q) begin
                pvalid_d = 1'b1;
                paddr_d  = in_waddr;
                pdata_d  = lane_data;
                pbe_d    = lane_be;
            end else if (in_waddr == paddr_q) begin
                if ((pbe_q & lane_be) == 2'b00) begin
                    push      = 1'b1;
                    push_data = merged_data;
                    push_be   = pbe_q | lane_be;
                    pvalid_d  = 1'b0;
                end else begin
                    pdata_d = merged_data;
                end
            end else begin
                // Jump to a new word: retire the pending one as a partial word
                push     = 1'b1;
                paddr_d  = in_waddr;
                pdata_d  = lane_data;
                pbe_d    = lane_be;
            end
        end else if (dl_fall && pvalid_q) begin
            push     = 1'b1;
            pvalid_d = 1'b0;
        end
    end

    // FIFO storage and occupancy
    logic [WA-1:0] mem_addr [DEPTH];
    logic [15:0]   mem_data [DEPTH];
    logic [1:0]    mem_be   [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_ok;
    logic          pop;
    state_t        state_q;

    assign fifo_full  = (cnt_q == CW'(DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign push_ok    = push & ~fifo_full;
    assign pop        = (state_q == S_WAIT) & sdram_ack;

    // NOTE: the storage array has no reset; occupancy is tracked by cnt_q, so stale contents are never read.
    always_ff @(posedge clk_rom) begin
        if (push_ok) begin
            mem_addr[wr_ptr_q] <= push_addr;
            mem_data[wr_ptr_q] <= push_data;
            mem_be[wr_ptr_q]   <= push_be;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            dl_q     <= 1'b0;
            pvalid_q <= 1'b0;
            paddr_q  <= '0;
            pdata_q  <= '0;
            pbe_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
        end else begin
            dl_q     <= downloading;
            pvalid_q <= pvalid_d;
            paddr_q  <= paddr_d;
            pdata_q  <= pdata_d;
            pbe_q    <= pbe_d;

            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase

            // A drop in the same cycle as a new start still counts against the new download
            if (push && fifo_full) begin
                overflow <= 1'b1;
            end else if (dl_rise) begin
                overflow <= 1'b0;
            end
        end
    end

    // Drain FSM with registered SDRAM-side outputs
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            sdram_din  <= '0;
            sdram_dsn  <= 2'b11;
            word_cnt   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        sdram_addr <= mem_addr[rd_ptr_q];
                        sdram_din  <= mem_data[rd_ptr_q];
                        sdram_dsn  <= ~mem_be[rd_ptr_q];
                        sdram_req  <= 1'b1;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        sdram_dsn <= 2'b11;
                        state_q   <= S_IDLE;
                    end
                end
                default: begin
                    sdram_req <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase

            if (dl_rise) begin
                word_cnt <= '0;
            end else if (pop) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    assign dwnld_busy = downloading | dl_q | pvalid_q | ~fifo_empty | sdram_req;

endmodule
